// File: rtl/segre_line_mem_responder.sv
// Main-memory line responder: serves one cache line read or write at a time
// after a fixed latency and signals completion with a single-cycle ready pulse.
module segre_line_mem_responder #(
   parameter int ADDR_SIZE   = 32,
   parameter int LINE_BYTES  = 16,
   parameter int DEPTH_LINES = 1024,
   parameter int LATENCY     = 4
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   input  logic                        rd_i,
   input  logic                        wr_i,
   input  logic [ADDR_SIZE-1:0]        addr_i,
   input  logic [LINE_BYTES-1:0][7:0]  wr_line_i,
   output logic [LINE_BYTES-1:0][7:0]  rd_line_o,
   output logic                        ready_o,
   output logic                        busy_o
);

   localparam int OFF_W  = $clog2(LINE_BYTES);
   localparam int IDX_W  = $clog2(DEPTH_LINES);
   localparam int LINE_W = LINE_BYTES * 8;
   localparam int CNT_W  = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;

   typedef enum logic [1:0] {IDLE, WAIT, RESP, GAP} state_t;

   state_t             state;
   state_t             state_next;
   logic [CNT_W-1:0]   cnt;
   logic [IDX_W-1:0]   idx_in;
   logic [IDX_W-1:0]   idx_q;
   logic [IDX_W-1:0]   rd_idx;
   logic [LINE_W-1:0]  line_q;
   logic               wr_q;
   logic               accept;
   logic               op_wr_next;
   logic               load_rd;
   logic               unused_addr;

   logic [LINE_W-1:0]  mem [DEPTH_LINES] = '{default: '0};

   assign idx_in      = addr_i[OFF_W +: IDX_W];
   assign unused_addr = ^{addr_i[OFF_W-1:0], addr_i[ADDR_SIZE-1:OFF_W+IDX_W]};

   always_comb begin
      state_next = state;
      accept     = 1'b0;
      case (state)
         IDLE: begin
            if (rd_i || wr_i) begin
               accept     = 1'b1;
               state_next = (LATENCY > 1) ? WAIT : RESP;
            end
         end
         WAIT:    if (cnt == '0) state_next = RESP;
         RESP:    state_next = GAP;
         GAP:     state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // With LATENCY=1 the read happens on the accept cycle, so the index and
   // op must come straight from the request rather than the latches.
   assign op_wr_next = accept ? wr_i : wr_q;
   assign rd_idx     = accept ? idx_in : idx_q;
   assign load_rd    = (state_next == RESP) && !op_wr_next;

   assign ready_o = (state == RESP);
   assign busy_o  = (state != IDLE);

   always_ff @(posedge clk_i) begin
      if (rst_i) state <= IDLE;
      else       state <= state_next;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt       <= '0;
         wr_q      <= 1'b0;
         rd_line_o <= '0;
      end else begin
         if (accept) begin
            wr_q <= wr_i;
            cnt  <= CNT_W'(LATENCY - 2);
         end else if (state == WAIT && cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
         end
         if (load_rd) rd_line_o <= mem[rd_idx];
      end
   end

   // Transaction payload is captured once and held; no reset needed on data.
   always_ff @(posedge clk_i) begin
      if (accept) begin
         idx_q  <= idx_in;
         line_q <= wr_line_i;
      end
   end

   // A write whose RESP cycle meets reset is dropped.
   always_ff @(posedge clk_i) begin
      if (state == RESP && wr_q && !rst_i) mem[idx_q] <= line_q;
   end

endmodule

// File: tb/tb_segre_line_mem_responder.sv
// Scoreboard bench for segre_line_mem_responder: timing, data, wrap, reset abort
// and LATENCY=1 back-to-back behaviour.
module tb_segre_line_mem_responder;

   localparam int LAT = 4;

   typedef logic [15:0][7:0] line_t;
   typedef struct {
      logic  is_rd;
      line_t line;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        rd, wr, rd1, wr1;
   logic [31:0] addr, addr1;
   line_t       wline, wline1, rline, rline1;
   logic        ready, busy, ready1, busy1;

   int    n_checks = 0;
   int    n_errors = 0;
   exp_t  sb[$];
   line_t model [1024];

   always #5 clk = ~clk;

   segre_line_mem_responder #(.ADDR_SIZE(32), .LINE_BYTES(16), .DEPTH_LINES(1024), .LATENCY(LAT)) dut (
      .clk_i(clk), .rst_i(rst), .rd_i(rd), .wr_i(wr), .addr_i(addr),
      .wr_line_i(wline), .rd_line_o(rline), .ready_o(ready), .busy_o(busy)
   );

   segre_line_mem_responder #(.ADDR_SIZE(32), .LINE_BYTES(16), .DEPTH_LINES(1024), .LATENCY(1)) dut1 (
      .clk_i(clk), .rst_i(rst), .rd_i(rd1), .wr_i(wr1), .addr_i(addr1),
      .wr_line_i(wline1), .rd_line_o(rline1), .ready_o(ready1), .busy_o(busy1)
   );

   task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic int line_idx(input logic [31:0] a);
      return int'((a >> 4) & 32'd1023);
   endfunction

   function automatic line_t ramp_line();
      line_t l;
      for (int i = 0; i < 16; i++) l[i] = 8'(i);
      return l;
   endfunction

   task automatic push_exp(input logic is_rd, input line_t l);
      exp_t e;
      e.is_rd = is_rd;
      e.line  = l;
      sb.push_back(e);
   endtask

   task automatic on_ready(input string tag, input line_t got);
      exp_t e;
      if (sb.size() == 0) begin
         check_val({tag, "_sb_underflow"}, 1, 0);
      end else begin
         e = sb.pop_front();
         if (e.is_rd) check_val({tag, "_rd_line"}, got, e.line);
      end
   endtask

   // One full transaction on the LATENCY=4 instance, checking every cycle.
   task automatic run_txn(input string tag, input logic r, input logic w,
                          input logic [31:0] a, input line_t l);
      push_exp(!w, w ? line_t'('0) : model[line_idx(a)]);
      if (w) model[line_idx(a)] = l;
      @(posedge clk); #1;
      rd = r; wr = w; addr = a; wline = l;
      for (int c = 0; c <= LAT + 2; c++) begin
         @(negedge clk);
         check_val({tag, "_ready"}, ready, c == LAT);
         check_val({tag, "_busy"}, busy, c >= 1 && c <= LAT + 1);
         if (ready) on_ready(tag, rline);
         if (c == LAT) begin rd = 1'b0; wr = 1'b0; end
      end
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) model[i] = '0;
      rst = 1'b1; rd = 0; wr = 0; addr = '0; wline = '0;
      rd1 = 0; wr1 = 0; addr1 = '0; wline1 = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check_val("rst_ready", ready, 0);
      check_val("rst_busy", busy, 0);
      check_val("rst_rd_line", rline, 0);
      check_val("rst_ready1", ready1, 0);

      // write ramp, then read it back with a non-zero offset
      run_txn("wr40", 1'b0, 1'b1, 32'h40, ramp_line());
      run_txn("rd4c", 1'b1, 1'b0, 32'h4C, '0);

      // read held after ready: GAP ignores it, IDLE re-accepts at cycle LAT+2
      push_exp(1'b1, model[line_idx(32'h40)]);
      push_exp(1'b1, model[line_idx(32'h40)]);
      @(posedge clk); #1;
      rd = 1'b1; addr = 32'h40;
      for (int c = 0; c <= 12; c++) begin
         @(negedge clk);
         check_val("hold_ready", ready, c == 4 || c == 10);
         check_val("hold_busy", busy, (c >= 1 && c <= 5) || (c >= 7 && c <= 11));
         if (ready) on_ready("hold", rline);
         if (c == 10) rd = 1'b0;
      end

      // simultaneous rd/wr resolves as a write
      run_txn("rdwr80", 1'b1, 1'b1, 32'h80, {16{8'hAA}});
      run_txn("rd80", 1'b1, 1'b0, 32'h80, '0);
      run_txn("rd200", 1'b1, 1'b0, 32'h200, '0);

      // address wrap modulo 16 KiB
      run_txn("wr4010", 1'b0, 1'b1, 32'h4010, {16{8'h55}});
      run_txn("rd0010", 1'b1, 1'b0, 32'h0010, '0);

      // reset in cycle 2 of a write aborts it
      @(posedge clk); #1;
      wr = 1'b1; addr = 32'h100; wline = {16{8'hFF}};
      for (int c = 0; c <= 6; c++) begin
         @(negedge clk);
         check_val("rstw_ready", ready, 0);
         check_val("rstw_busy", busy, c == 1 || c == 2);
         if (c == 3) check_val("rstw_rd_line", rline, 0);
         if (c == 1) begin @(posedge clk); #1; rst = 1'b1; end
         if (c == 2) begin @(posedge clk); #1; rst = 1'b0; wr = 1'b0; end
      end
      run_txn("rd100", 1'b1, 1'b0, 32'h100, '0);

      // LATENCY=1: write then back-to-back read of the same line
      push_exp(1'b0, '0);
      push_exp(1'b1, {16{8'h3C}});
      @(posedge clk); #1;
      wr1 = 1'b1; addr1 = 32'h40; wline1 = {16{8'h3C}};
      for (int c = 0; c <= 6; c++) begin
         @(negedge clk);
         check_val("l1_ready", ready1, c == 1 || c == 4);
         check_val("l1_busy", busy1, c == 1 || c == 2 || c == 4 || c == 5);
         if (ready1) on_ready("l1", rline1);
         if (c == 2) begin @(posedge clk); #1; wr1 = 1'b0; rd1 = 1'b1; end
         if (c == 4) rd1 = 1'b0;
      end

      check_val("sb_empty", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
